// File: rtl/db15_pkg.sv
`default_nettype none
// ============================================================================
// Module   : db15_pkg
// Purpose  : Shared DB15 joystick-link constants, word type and frame helper.
// Revision : 1.0 - initial release
// ============================================================================
package db15_pkg;

    localparam int BTN_R     = 0;
    localparam int BTN_L     = 1;
    localparam int BTN_D     = 2;
    localparam int BTN_U     = 3;
    localparam int BTN_A     = 4;
    localparam int BTN_B     = 5;
    localparam int BTN_C     = 6;
    localparam int BTN_X     = 7;
    localparam int BTN_Y     = 8;
    localparam int BTN_Z     = 9;
    localparam int BTN_START = 10;
    localparam int BTN_MODE  = 11;

    localparam int DB15_W = 16;

    typedef logic [DB15_W-1:0] joy_word_t;

    function automatic int frame_bits(input int w);
        return 2 * w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : sync_edge
// Purpose  : Synchronizer, optional majority filter (DB15_TX_FILTER_EN) and
//            rise/fall detector for one asynchronous pin.
// Revision : 1.0 - initial release
// ============================================================================
module sync_edge
    import db15_pkg::*;
#(
    parameter int   SYNC    = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

`ifdef DB15_TX_FILTER_EN
    localparam int VLEN = SYNC + 2;
`else
    localparam int VLEN = SYNC;
`endif

    logic [SYNC-1:0] sync_q;
    logic [VLEN-1:0] valid_q;
    logic            prev_q;
    logic            armed_q;
    logic            sync_w;
    logic            filt_w;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= {SYNC{RST_VAL}};
            valid_q <= '0;
        end else begin
            sync_q  <= {sync_q[SYNC-2:0], pin_i};
            valid_q <= {valid_q[VLEN-2:0], 1'b1};
        end
    end

    assign sync_w = sync_q[SYNC-1];

`ifdef DB15_TX_FILTER_EN
    logic [1:0] hist_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= {2{RST_VAL}};
        end else begin
            hist_q <= {hist_q[0], sync_w};
        end
    end

    assign filt_w = (sync_w & hist_q[0]) | (sync_w & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
    assign filt_w = sync_w;
`endif

    // Edges count only once a genuine low sample has followed reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q  <= RST_VAL;
            armed_q <= 1'b0;
        end else begin
            prev_q <= filt_w;
            if (valid_q[VLEN-1] && !filt_w) begin
                armed_q <= 1'b1;
            end
        end
    end

    assign level_o = filt_w;
    assign rise_o  = armed_q &  filt_w & ~prev_q;
    assign fall_o  = armed_q & ~filt_w &  prev_q;

endmodule
`default_nettype wire

// File: rtl/joy_db15_tx.sv
`default_nettype none
// ============================================================================
// Module   : joy_db15_tx
// Purpose  : Device end of the DB15 serial joystick link (PISO shift chain).
//            Optional glitch filter enabled by DB15_TX_FILTER_EN.
// Revision : 1.0 - initial release
// ============================================================================
module joy_db15_tx
    import db15_pkg::*;
#(
    parameter int W    = 16,
    parameter int SYNC = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [W-1:0]               joy_in1,
    input  logic [W-1:0]               joy_in2,
    input  logic                       joy_clk,
    input  logic                       joy_load,
    output logic                       joy_data,
    output logic                       busy,
    output logic                       frame_done,
    output logic [$clog2(2*W+1)-1:0]   bit_idx
);

    localparam int             NBITS    = frame_bits(W);
    localparam int             IW       = $clog2(NBITS + 1);
    localparam logic [IW-1:0]  IDX_LAST = IW'(NBITS - 1);
    localparam logic [IW-1:0]  IDX_IDLE = IW'(NBITS);

    logic             clk_lvl_w, clk_rise_w, clk_fall_w;
    logic             load_lvl_w, load_rise_w, load_fall_w;
    logic [NBITS-1:0] sr_q, sr_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             data_q;
    logic             unused_ok;

    sync_edge #(.SYNC(SYNC), .RST_VAL(1'b0)) u_sync_clk (
        .clk     (clk),
        .rst_n   (reset_n),
        .pin_i   (joy_clk),
        .level_o (clk_lvl_w),
        .rise_o  (clk_rise_w),
        .fall_o  (clk_fall_w)
    );

    // Load idles high so reset release never looks like a load.
    sync_edge #(.SYNC(SYNC), .RST_VAL(1'b1)) u_sync_load (
        .clk     (clk),
        .rst_n   (reset_n),
        .pin_i   (joy_load),
        .level_o (load_lvl_w),
        .rise_o  (load_rise_w),
        .fall_o  (load_fall_w)
    );

    assign unused_ok = &{1'b0, clk_lvl_w, clk_fall_w, load_rise_w, load_fall_w};

    always_comb begin
        sr_d   = sr_q;
        idx_d  = idx_q;
        busy_d = busy_q;
        done_d = 1'b0;
        if (!load_lvl_w) begin
            sr_d   = {joy_in2, joy_in1};
            idx_d  = '0;
            busy_d = 1'b1;
        end else if (clk_rise_w) begin
            sr_d = {1'b0, sr_q[NBITS-1:1]};
            if (idx_q != IDX_IDLE) begin
                idx_d = idx_q + 1'b1;
            end
            if (idx_q == IDX_LAST) begin
                done_d = 1'b1;
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sr_q   <= '0;
            idx_q  <= IDX_IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            data_q <= 1'b1;
        end else begin
            sr_q   <= sr_d;
            idx_q  <= idx_d;
            busy_q <= busy_d;
            done_q <= done_d;
            data_q <= ~sr_d[0];
        end
    end

    assign joy_data   = data_q;
    assign busy       = busy_q;
    assign frame_done = done_q;
    assign bit_idx    = idx_q;

endmodule
`default_nettype wire

// File: tb/tb_joy_db15_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_joy_db15_tx
// Purpose  : Self-checking bench for joy_db15_tx acting as the console reader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_joy_db15_tx;

    localparam int W  = 16;
    localparam int NB = 32;
`ifdef DB15_TX_FILTER_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    logic         clk      = 1'b0;
    logic         reset_n  = 1'b0;
    logic [W-1:0] joy_in1  = '0;
    logic [W-1:0] joy_in2  = '0;
    logic         joy_clk  = 1'b0;
    logic         joy_load = 1'b1;
    wire          joy_data;
    wire          busy;
    wire          frame_done;
    wire  [5:0]   bit_idx;

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;

    joy_db15_tx #(.W(W), .SYNC(2)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .joy_in1    (joy_in1),
        .joy_in2    (joy_in2),
        .joy_clk    (joy_clk),
        .joy_load   (joy_load),
        .joy_data   (joy_data),
        .busy       (busy),
        .frame_done (frame_done),
        .bit_idx    (bit_idx)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done === 1'b1) done_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s[%0d]: observed %h expected %h", tag, k, obs, exp);
    endtask

    // Reference: wire level of serial bit k of frame word f (pressed = 0).
    function automatic logic exp_bit(input logic [31:0] f, input int k);
        return (k < NB) ? ~f[k] : 1'b1;
    endfunction

    function automatic logic [31:0] exp_idx(input int k);
        return (k < NB) ? 32'(k) : 32'(NB);
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load_pulse();
        joy_load = 1'b0;
        cyc(6);
        joy_load = 1'b1;
        cyc(6);
    endtask

    task automatic shift();
        joy_clk = 1'b1;
        cyc(6);
        joy_clk = 1'b0;
        cyc(6);
    endtask

    task automatic walk(input string tag, input logic [31:0] f, input int k0, input int k1);
        for (int k = k0 + 1; k <= k1; k++) begin
            shift();
            chk(tag, k, 32'(joy_data), 32'(exp_bit(f, k)));
            chk({tag, "_idx"}, k, 32'(bit_idx), exp_idx(k));
        end
    endtask

    initial begin
        logic [31:0] f;
        logic [31:0] dec;
        int          d0;

        // Reset with random pins
        joy_in1  = W'($urandom);
        joy_in2  = W'($urandom);
        joy_clk  = 1'($urandom);
        joy_load = 1'($urandom);
        cyc(4);
        chk("rst_data", 0, 32'(joy_data), 32'd1);
        chk("rst_busy", 0, 32'(busy), 32'd0);
        chk("rst_idx", 0, 32'(bit_idx), 32'd32);
        chk("rst_done", 0, 32'(frame_done), 32'd0);
        joy_load = 1'b1;
        joy_clk  = 1'b0;
        cyc(2);
        reset_n = 1'b1;
        cyc(4);
        repeat (4) shift();
        chk("noload_data", 0, 32'(joy_data), 32'd1);
        chk("noload_busy", 0, 32'(busy), 32'd0);
        chk("noload_idx", 0, 32'(bit_idx), 32'd32);
        chk("noload_done", 0, 32'(done_cnt), 32'd0);

        // Directed frame
        joy_in1 = 16'h0011;
        joy_in2 = 16'h8000;
        f  = 32'h8000_0011;
        d0 = done_cnt;
        joy_load = 1'b0;
        cyc(6);
        chk("frm_busy_load", 0, 32'(busy), 32'd1);
        chk("frm_idx_load", 0, 32'(bit_idx), 32'd0);
        joy_load = 1'b1;
        cyc(6);
        chk("frm", 0, 32'(joy_data), 32'(exp_bit(f, 0)));
        walk("frm", f, 0, NB - 1);
        chk("frm_done_early", 31, 32'(done_cnt), 32'(d0));
        chk("frm_busy_31", 31, 32'(busy), 32'd1);
        walk("frm", f, NB - 1, NB);
        chk("frm_done", 32, 32'(done_cnt), 32'(d0 + 1));
        chk("frm_busy_end", 32, 32'(busy), 32'd0);

        // Latency: load pin to joy_data, then clk pin to next bit
        joy_in1 = 16'h0001;
        joy_in2 = 16'h0000;
        joy_load = 1'b0;
        for (int c = 1; c <= LAT; c++) begin
            @(posedge clk);
            @(negedge clk);
            chk("lat_load", c, 32'(joy_data), (c < LAT) ? 32'd1 : 32'd0);
        end
        cyc(6);
        joy_load = 1'b1;
        cyc(6);
        joy_clk = 1'b1;
        for (int c = 1; c <= LAT; c++) begin
            @(posedge clk);
            @(negedge clk);
            chk("lat_clk", c, 32'(joy_data), (c < LAT) ? 32'd0 : 32'd1);
        end
        cyc(6);
        joy_clk = 1'b0;
        cyc(6);

        // Collision: load and clk edge together, load wins
        f = $urandom;
        joy_in1 = f[15:0];
        joy_in2 = f[31:16];
        load_pulse();
        walk("col_pre", f, 0, 5);
        joy_load = 1'b0;
        joy_clk  = 1'b1;
        cyc(6);
        joy_load = 1'b1;
        cyc(6);
        chk("col_idx", 0, 32'(bit_idx), 32'd0);
        chk("col_data", 0, 32'(joy_data), 32'(exp_bit(f, 0)));
        joy_clk = 1'b0;
        cyc(6);
        walk("col_post", f, 0, 10);

        // Abort at bit 10 and restart
        d0 = done_cnt;
        load_pulse();
        chk("abort_idx", 0, 32'(bit_idx), 32'd0);
        chk("abort_done", 0, 32'(done_cnt), 32'(d0));
        chk("abort_data", 0, 32'(joy_data), 32'(exp_bit(f, 0)));
        walk("restart", f, 0, NB);
        chk("restart_done", NB, 32'(done_cnt), 32'(d0 + 1));

        // Overrun: 40 edges
        f = $urandom;
        joy_in1 = f[15:0];
        joy_in2 = f[31:16];
        d0 = done_cnt;
        load_pulse();
        walk("ovr", f, 0, 40);
        chk("ovr_done", 40, 32'(done_cnt), 32'(d0 + 1));

`ifdef DB15_TX_FILTER_EN
        // Single-cycle glitch on joy_clk must be ignored
        load_pulse();
        joy_clk = 1'b1;
        cyc(1);
        joy_clk = 1'b0;
        cyc(6);
        chk("glitch_idx", 0, 32'(bit_idx), 32'd0);
        chk("glitch_data", 0, 32'(joy_data), 32'(exp_bit(f, 0)));
`endif

        // Async reset mid-frame
        load_pulse();
        walk("prerst", f, 0, 17);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_data", 17, 32'(joy_data), 32'd1);
        chk("arst_busy", 17, 32'(busy), 32'd0);
        chk("arst_idx", 17, 32'(bit_idx), 32'd32);
        chk("arst_done", 17, 32'(frame_done), 32'd0);
        cyc(3);
        reset_n = 1'b1;
        cyc(4);

        // Random frames decoded by the reader; load tracks live inputs
        for (int r = 0; r < 3; r++) begin
            d0 = done_cnt;
            joy_in1 = W'($urandom);
            joy_in2 = W'($urandom);
            joy_load = 1'b0;
            cyc(3);
            f = $urandom;
            joy_in1 = f[15:0];
            joy_in2 = f[31:16];
            cyc(6);
            joy_load = 1'b1;
            cyc(6);
            joy_in1 = W'($urandom);
            joy_in2 = W'($urandom);
            dec = '0;
            for (int k = 0; k < NB; k++) begin
                if (k > 0) shift();
                dec[k] = ~joy_data;
            end
            chk("dec_word", r, dec, f);
            chk("dec_busy", r, 32'(busy), 32'd1);
            shift();
            chk("dec_done", r, 32'(done_cnt), 32'(d0 + 1));
            chk("dec_idle", r, 32'(bit_idx), 32'd32);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
